// File: rtl/link_arbiter.sv
// link_arbiter: four-requester arbiter driving a single interconnect link.
// Each grant runs START (1 cycle), HOLD (HOLD_CYCLES cycles) and GAP (1 cycle).
// GAP re-arbitrates, so back-to-back transfers need no IDLE cycle between them.
// Arbitration is round-robin by default. Defining LINK_ARB_FIXED_PRIO_EN
// selects fixed priority (lowest index wins) with identical timing.
// HOLD_CYCLES legal range: 1..15.
module link_arbiter #(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       start,
   output logic       link_active,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_HOLD  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_gnt;
   logic [1:0] r_gnt_id;
   logic [3:0] r_cnt;
   logic [1:0] w_base;
   logic       w_hit;
   logic [1:0] w_idx;
   logic       w_hold_last;

   assign gnt         = r_gnt;
   assign gnt_id      = r_gnt_id;
   assign w_hold_last = (r_state == S_HOLD) && (r_cnt == 4'd0);

`ifdef LINK_ARB_FIXED_PRIO_EN
   // Fixed priority: the search always starts at requester 0.
   assign w_base = 2'd0;
`else
   logic [1:0] r_ptr;

   // Round-robin pointer moves past the winner as the transfer enters GAP,
   // so the re-arbitration in GAP already sees the advanced pointer.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_ptr <= 2'd0;
      else if (w_hold_last)
         r_ptr <= r_gnt_id + 2'd1;
   end

   assign w_base = r_ptr;
`endif

   // Find the first asserted request at or after w_base, wrapping 3 -> 0.
   always_comb begin
      logic [1:0] v_cand;
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_hit  = 1'b0;
      w_idx  = 2'd0;
      v_cand = 2'd0;
      // Scan from the farthest offset down so the nearest hit wins last.
      for (int i = 3; i >= 0; i--) begin
         v_cand = w_base + 2'(i);
         if (req[v_cand]) begin
            w_hit = 1'b1;
            w_idx = v_cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic and state-decoded link handshake outputs.
   always_comb begin
      w_next      = r_state;
      start       = 1'b0;
      link_active = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_hit)
               w_next = S_START;
         end
         S_START: begin
            start       = 1'b1;
            link_active = 1'b1;
            w_next      = S_HOLD;
         end
         S_HOLD: begin
            link_active = 1'b1;
            if (r_cnt == 4'd0)
               w_next = S_GAP;
         end
         S_GAP: begin
            done   = 1'b1;
            w_next = w_hit ? S_START : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Grant, grant index and hold counter. req is only looked at in IDLE/GAP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gnt    <= 4'd0;
         r_gnt_id <= 2'd0;
         r_cnt    <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE, S_GAP: begin
               if (w_hit) begin
                  r_gnt    <= 4'b0001 << w_idx;
                  r_gnt_id <= w_idx;
               end else begin
                  r_gnt    <= 4'd0;
               end
            end
            S_START: r_cnt <= HOLD_LOAD;
            S_HOLD: begin
               if (r_cnt == 4'd0)
                  r_gnt <= 4'd0;
               else
                  r_cnt <= r_cnt - 4'd1;
            end
            default: r_gnt <= 4'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: table-driven check of link_arbiter with HOLD_CYCLES=2
// (dut_a) and HOLD_CYCLES=1 (dut_b), plus a hand-written handshake sequence.
// Expected grant orders follow LINK_ARB_FIXED_PRIO_EN when it is defined.
module tb_link_arbiter;

`ifdef LINK_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'd0;

   logic [3:0] a_gnt, b_gnt;
   logic [1:0] a_id, b_id;
   logic       a_st, a_la, a_dn, b_st, b_la, b_dn;

   link_arbiter #(.HOLD_CYCLES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(a_gnt), .gnt_id(a_id),
      .start(a_st), .link_active(a_la), .done(a_dn)
   );

   link_arbiter #(.HOLD_CYCLES(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(b_gnt), .gnt_id(b_id),
      .start(b_st), .link_active(b_la), .done(b_dn)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         sel;   // 0: dut_a, 1: dut_b
      bit         rst_n;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      bit         st;
      bit         la;
      bit         dn;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit s, input bit r, input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] id, input bit st, input bit la, input bit dn);
      vec_t v;
      v.sel = s; v.rst_n = r; v.req = rq; v.gnt = g; v.id = id;
      v.st = st; v.la = la; v.dn = dn;
      vecs.push_back(v);
   endtask

   // One full transfer with req held: START, HOLD x hold, GAP.
   task automatic xfer(input bit s, input logic [3:0] rq, input logic [1:0] id, input int hold);
      add(s, 1'b1, rq, 4'b0001 << id, id, 1'b1, 1'b1, 1'b0);
      for (int h = 0; h < hold; h++)
         add(s, 1'b1, rq, 4'b0001 << id, id, 1'b0, 1'b1, 1'b0);
      add(s, 1'b1, rq, 4'd0, id, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [8:0] act, exp;
      int         la_cycles;
      bit         seen;

      // Single one-cycle request.
      add(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      add(0, 1, 4'b0001, 4'b0001, 2'd0, 1, 1, 0);
      add(0, 1, 4'b0000, 4'b0001, 2'd0, 0, 1, 0);
      add(0, 1, 4'b0000, 4'b0001, 2'd0, 0, 1, 0);
      add(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 1);
      add(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);

      // All requesters held: 0,1,2,3,0 (round-robin) or 0 repeatedly (fixed).
      add(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      for (int k = 0; k < 5; k++)
         xfer(0, 4'b1111, FIXED ? 2'd0 : 2'(k % 4), 2);

      // Request withdrawn (and others raised) mid-transfer; gnt_id retained.
      add(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      add(0, 1, 4'b0100, 4'b0100, 2'd2, 1, 1, 0);
      add(0, 1, 4'b1011, 4'b0100, 2'd2, 0, 1, 0);
      add(0, 1, 4'b0000, 4'b0100, 2'd2, 0, 1, 0);
      add(0, 1, 4'b0000, 4'b0000, 2'd2, 0, 0, 1);
      add(0, 1, 4'b0000, 4'b0000, 2'd2, 0, 0, 0);

      // Reset in the second HOLD cycle: outputs clear, no done, pointer to 0.
      add(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      xfer(0, 4'b0010, 2'd1, 2);
      add(0, 1, 4'b0000, 4'b0000, 2'd1, 0, 0, 0);
      add(0, 1, 4'b0010, 4'b0010, 2'd1, 1, 1, 0);
      add(0, 1, 4'b0000, 4'b0010, 2'd1, 0, 1, 0);
      add(0, 1, 4'b0000, 4'b0010, 2'd1, 0, 1, 0);
      add(0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      add(0, 1, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      add(0, 1, 4'b1111, 4'b0001, 2'd0, 1, 1, 0);

      // HOLD_CYCLES=1 with req=0011 held: two-cycle link window, 0,1 alternating.
      add(1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0);
      for (int k = 0; k < 6; k++)
         xfer(1, 4'b0011, FIXED ? 2'd0 : 2'(k % 2), 1);

      // Apply each vector before the edge, sample 1 time unit after it.
      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n;
         req   = vecs[i].req;
         @(posedge clk);
         #1;
         act = vecs[i].sel ? {b_gnt, b_id, b_st, b_la, b_dn}
                           : {a_gnt, a_id, a_st, a_la, a_dn};
         exp = {vecs[i].gnt, vecs[i].id, vecs[i].st, vecs[i].la, vecs[i].dn};
         check($sformatf("vec%0d gnt/id/st/la/dn", i), 16'(act), 16'(exp));
      end

      // Hand-written: requester 3 alone, handshake consistency every cycle.
      rst_n = 1'b0;
      req   = 4'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = 4'b1000;
      seen  = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         #1;
         seen = a_st;
      end
      check("start_seen", 16'(seen), 16'd1);
      la_cycles = a_la ? 1 : 0;
      req  = 4'd0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         #1;
         la_cycles += a_la ? 1 : 0;
         check("handshake_consistency", {14'd0, a_st & ~a_la, a_dn & a_la}, 16'd0);
         seen = a_dn;
      end
      check("done_seen", 16'(seen), 16'd1);
      check("link_active_cycles", 16'(la_cycles), 16'd3);
      check("gnt_id_at_done", 16'(a_id), 16'd3);
      @(posedge clk);
      #1;
      check("idle_gnt_id_kept", {10'd0, a_gnt, a_id}, {10'd0, 4'd0, 2'd3});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
